tt_um_accelshark_psg_mixer: RTL and testbench
=============================================

Name: tt_um_accelshark_psg_mixer

Overview:
- Stereo voice mixer directly upstream of the I2S output stage; produces the 8-bit mix_l/mix_r words that the I2S stage serialises.
- Runs on the I2S bit clock (sclk) and is frame-synchronised to lrck.
- Once per frame it snapshots all voice samples, then scales and pans them and accumulates one voice per cycle.
- It saturates the sums and updates the held output words, which stay stable for the rest of the frame.

Parameters:
- VOICES, 4, number of voice inputs; must satisfy VOICES+2 <= FRAME_SCLK.
- FRAME_SCLK, 16, sclk cycles per lrck period; used only for the elaboration-time check above.

Ports:
- sclk  input  1  clock; all logic on posedge sclk.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  design enable.
- lrck  input  1  I2S word select; its rising edge marks the frame start. Sampled on posedge sclk.
- voice_sample  input  VOICES*8  unsigned samples; voice i at [8i+7:8i].
- voice_vol  input  VOICES*4  volume 0..15; voice i at [4i+3:4i].
- voice_pan_l  input  VOICES  bit i=1: voice i routed to left.
- voice_pan_r  input  VOICES  bit i=1: voice i routed to right.
- mix_l  output  8  left mixed word, held between updates.
- mix_r  output  8  right mixed word, held between updates.
- mix_valid  output  1  one-cycle pulse in the cycle mix_l/mix_r update.
- clip_l  output  1  left sum saturated in the last completed frame.
- clip_r  output  1  right sum saturated in the last completed frame.

Behaviour:
- Reset:
  - mix_l=0, mix_r=0, mix_valid=0, clip_l=0, clip_r=0.
  - state=IDLE, lrck_q=0, accumulators=0, snapshot regs=0.
- Edge detect:
  - lrck_q registers lrck every cycle.
  - Frame start (cycle k) = lrck==1 && lrck_q==0 && ena==1.
- States:
  - IDLE: wait for frame start.
  - ACCUM: phase p=0..VOICES-1.
  - WRITE: one cycle.
- Transitions:
  - On frame start, in any state: snapshot voice_sample/vol/pan_l/pan_r into regs, clear acc_l/acc_r, set p=0, go to ACCUM.
  - ACCUM at p=VOICES-1 -> WRITE.
  - WRITE -> IDLE.
- Arithmetic for voice p, at cycle k+1+p:
  - term = (sample_p * vol_p) >> 4, 12-bit product truncated to 8 bits (max 0xEF).
  - acc_l += term if pan_l[p]; acc_r += term if pan_r[p].
  - Accumulator width is 8+clog2(VOICES) bits; no overflow is possible.
- WRITE at cycle k+VOICES+1 (k+5 for the default):
  - mix_x = (acc_x > 255) ? 8'hFF : acc_x[7:0].
  - clip_x = (acc_x > 255).
  - mix_valid=1 for this cycle only; 0 in every other cycle.
- Latency: first valid output VOICES+1 cycles after the frame-start cycle.
- Input changes after the snapshot cycle have no effect until the next frame start.
- Boundary conditions:
  - Frame start during ACCUM or WRITE restarts the sequence: accumulators cleared, no mix_valid for the aborted frame, outputs keep their previous values.
  - No lrck edge: block stays in IDLE and outputs hold indefinitely.
  - ena low: frame starts are ignored. An in-progress ACCUM/WRITE aborts to IDLE the next cycle with no mix_valid. Outputs hold.
  - vol=0 or both pan bits 0: the voice contributes 0.
  - lrck high out of reset (lrck_q=0) counts as a frame start if ena=1.
  - rst_n asserted mid-frame: immediate return to reset values.

Decomposition:
- Shared include psg_defs.vh holds:
  - SAMPLE_W=8, VOL_W=4, VOL_SHIFT=4.
  - State encodings IDLE=2'd0, ACCUM=2'd1, WRITE=2'd2.
  - The saturation constant 8'hFF.
- Sub-module tt_um_accelshark_psg_mixer_scale: combinational sample*vol>>4 for the one voice selected by the phase mux. Instantiated once, time-shared across voices.

Test Plan:
- Reset, then hold rst_n low -> mix_l=mix_r=0x00, mix_valid=0, clip_l=clip_r=0 throughout.
- Voice0 sample=0x80 vol=15 pan_l=1 pan_r=0, other vols 0, lrck rise -> at k+5 mix_l=0x78, mix_r=0x00, mix_valid=1 for exactly one cycle.
- All 4 voices sample=0xFF vol=15 both pans -> sum 0x3BC -> mix_l=mix_r=0xFF, clip_l=clip_r=1.
- Voice0 sample=0x40 vol=8 pan_r, then change sample to 0xFF at k+1 -> mix_r=0x20 (snapshot value used), mix_l=0x00.
- Second lrck rise at k+3 -> no mix_valid at k+5; mix_valid at (k+3)+5; outputs unchanged until then.
- ena=0 with lrck toggling for 3 frames -> mix_valid never asserts; mix_l/mix_r hold the last values.

Source files
------------

// File: rtl/tt_um_accelshark_psg_mixer_pkg.sv
// +----------------------------------------------------------------------+
// | tt_um_accelshark_psg_mixer_pkg: shared widths, constants, FSM states  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package tt_um_accelshark_psg_mixer_pkg;

  localparam int SAMPLE_W  = 8;
  localparam int VOL_W     = 4;
  localparam int VOL_SHIFT = 4;

  localparam logic [SAMPLE_W-1:0] SAT_VAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tt_um_accelshark_psg_mixer_scale.sv
// +----------------------------------------------------------------------+
// | tt_um_accelshark_psg_mixer_scale: (sample * vol) >> 4, one voice      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tt_um_accelshark_psg_mixer_scale
  import tt_um_accelshark_psg_mixer_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [VOL_W-1:0]    vol,
  output logic [SAMPLE_W-1:0] term
);

  logic [SAMPLE_W+VOL_W-1:0] product;

  assign product = {{VOL_W{1'b0}}, sample} * {{SAMPLE_W{1'b0}}, vol};
  // The product never exceeds 0xEF1, so the shifted value always fits in 8 bits.
  assign term    = SAMPLE_W'(product >> VOL_SHIFT);

endmodule

`default_nettype wire

// File: rtl/tt_um_accelshark_psg_mixer.sv
// +----------------------------------------------------------------------+
// | tt_um_accelshark_psg_mixer: frame-synchronous stereo voice mixer      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tt_um_accelshark_psg_mixer
  import tt_um_accelshark_psg_mixer_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int FRAME_SCLK = 16
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         lrck,
  input  logic [VOICES*SAMPLE_W-1:0]   voice_sample,
  input  logic [VOICES*VOL_W-1:0]      voice_vol,
  input  logic [VOICES-1:0]            voice_pan_l,
  input  logic [VOICES-1:0]            voice_pan_r,
  output logic [SAMPLE_W-1:0]          mix_l,
  output logic [SAMPLE_W-1:0]          mix_r,
  output logic                         mix_valid,
  output logic                         clip_l,
  output logic                         clip_r
);

  localparam int PW    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int ACC_W = SAMPLE_W + $clog2(VOICES);
  localparam logic [PW-1:0] LAST_P = PW'(VOICES - 1);

  if ((VOICES < 1) || (VOICES + 2 > FRAME_SCLK)) begin : g_frame_check
    $error("VOICES+2 must not exceed FRAME_SCLK");
  end

  state_t                       state;
  state_t                       state_nx;
  logic                         lrck_q;
  logic                         frame_start;
  logic                         last_phase;
  logic [PW-1:0]                phase;
  logic [ACC_W-1:0]             acc_l;
  logic [ACC_W-1:0]             acc_r;
  logic [VOICES*SAMPLE_W-1:0]   snap_sample;
  logic [VOICES*VOL_W-1:0]      snap_vol;
  logic [VOICES-1:0]            snap_pan_l;
  logic [VOICES-1:0]            snap_pan_r;
  logic [SAMPLE_W-1:0]          sel_sample;
  logic [VOL_W-1:0]             sel_vol;
  logic [SAMPLE_W-1:0]          term;
  logic [ACC_W-1:0]             sum_l;
  logic [ACC_W-1:0]             sum_r;
  logic                         over_l;
  logic                         over_r;

  assign frame_start = lrck && !lrck_q && ena;
  assign last_phase  = (phase == LAST_P);

  // One scaler shared by all voices; the phase counter selects the operand.
  assign sel_sample = snap_sample[phase*SAMPLE_W +: SAMPLE_W];
  assign sel_vol    = snap_vol[phase*VOL_W +: VOL_W];

  tt_um_accelshark_psg_mixer_scale u_scale (
    .sample (sel_sample),
    .vol    (sel_vol),
    .term   (term)
  );

  assign sum_l  = acc_l + (snap_pan_l[phase] ? ACC_W'(term) : '0);
  assign sum_r  = acc_r + (snap_pan_r[phase] ? ACC_W'(term) : '0);
  assign over_l = (sum_l > ACC_W'(255));
  assign over_r = (sum_r > ACC_W'(255));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (frame_start) begin
      state_nx = ACCUM;
    end else if (!ena) begin
      state_nx = IDLE;
    end else begin
      case (state)
        ACCUM:   if (last_phase) state_nx = WRITE;
        WRITE:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The final voice is folded in on the edge entering WRITE so that the
  // registered words and mix_valid are both visible during the WRITE cycle.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_q      <= 1'b0;
      phase       <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      snap_sample <= '0;
      snap_vol    <= '0;
      snap_pan_l  <= '0;
      snap_pan_r  <= '0;
      mix_l       <= '0;
      mix_r       <= '0;
      mix_valid   <= 1'b0;
      clip_l      <= 1'b0;
      clip_r      <= 1'b0;
    end else begin
      lrck_q    <= lrck;
      mix_valid <= 1'b0;
      if (frame_start) begin
        snap_sample <= voice_sample;
        snap_vol    <= voice_vol;
        snap_pan_l  <= voice_pan_l;
        snap_pan_r  <= voice_pan_r;
        acc_l       <= '0;
        acc_r       <= '0;
        phase       <= '0;
      end else if ((state == ACCUM) && ena) begin
        acc_l <= sum_l;
        acc_r <= sum_r;
        phase <= phase + PW'(1);
        if (last_phase) begin
          mix_l     <= over_l ? SAT_VAL : sum_l[SAMPLE_W-1:0];
          mix_r     <= over_r ? SAT_VAL : sum_r[SAMPLE_W-1:0];
          clip_l    <= over_l;
          clip_r    <= over_r;
          mix_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_um_accelshark_psg_mixer.sv
// +----------------------------------------------------------------------+
// | tb_tt_um_accelshark_psg_mixer: self-checking bench for the mixer      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tt_um_accelshark_psg_mixer;

  localparam int VOICES = 4;

  logic                sclk = 1'b0;
  logic                rst_n;
  logic                ena;
  logic                lrck;
  logic [VOICES*8-1:0] voice_sample;
  logic [VOICES*4-1:0] voice_vol;
  logic [VOICES-1:0]   voice_pan_l;
  logic [VOICES-1:0]   voice_pan_r;
  logic [7:0]          mix_l;
  logic [7:0]          mix_r;
  logic                mix_valid;
  logic                clip_l;
  logic                clip_r;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_l, exp_r;
  logic       exp_cl, exp_cr;

  tt_um_accelshark_psg_mixer #(.VOICES(VOICES), .FRAME_SCLK(16)) dut (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .ena          (ena),
    .lrck         (lrck),
    .voice_sample (voice_sample),
    .voice_vol    (voice_vol),
    .voice_pan_l  (voice_pan_l),
    .voice_pan_r  (voice_pan_r),
    .mix_l        (mix_l),
    .mix_r        (mix_r),
    .mix_valid    (mix_valid),
    .clip_l       (clip_l),
    .clip_r       (clip_r)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Reference: scaled voices summed per side, clamped at 255.
  function automatic void model(input logic [VOICES*8-1:0] s, input logic [VOICES*4-1:0] v,
                                input logic [VOICES-1:0] pl, input logic [VOICES-1:0] pr,
                                output logic [7:0] ml, output logic [7:0] mr,
                                output logic cl, output logic cr);
    int sl, sr, t;
    sl = 0;
    sr = 0;
    for (int i = 0; i < VOICES; i++) begin
      t = (int'(s[8*i +: 8]) * int'(v[4*i +: 4])) / 16;
      if (pl[i]) sl += t;
      if (pr[i]) sr += t;
    end
    cl = (sl > 255);
    cr = (sr > 255);
    ml = cl ? 8'hFF : 8'(sl);
    mr = cr ? 8'hFF : 8'(sr);
  endfunction

  task automatic randomize_voices();
    voice_sample = $urandom;
    voice_vol    = 16'($urandom);
    voice_pan_l  = 4'($urandom);
    voice_pan_r  = 4'($urandom);
  endtask

  // Caller raises lrck in cycle k; tick i of this loop lands in cycle k+i.
  // mode 1 scrambles voice inputs after the snapshot, mode 2 forces them to all-ones.
  task automatic observe(input int n, input int mode, output int first, output int nvalid,
                         output logic [7:0] ol, output logic [7:0] obr,
                         output logic ocl, output logic ocr, output bit early);
    logic [7:0] l0, r0;
    logic       cl0, cr0;
    l0 = mix_l; r0 = mix_r; cl0 = clip_l; cr0 = clip_r;
    first = -1; nvalid = 0; early = 0;
    ol = mix_l; obr = mix_r; ocl = clip_l; ocr = clip_r;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) begin
        lrck = 1'b0;
        if (mode == 1) randomize_voices();
        if (mode == 2) begin
          voice_sample = '1; voice_vol = '1; voice_pan_l = '1; voice_pan_r = '1;
        end
      end
      if (mix_valid === 1'b1) begin
        if (first < 0) first = i;
        nvalid++;
        ol = mix_l; obr = mix_r; ocl = clip_l; ocr = clip_r;
      end else if (first < 0 && ({mix_l, mix_r, clip_l, clip_r} !== {l0, r0, cl0, cr0})) begin
        early = 1;
      end
    end
  endtask

  task automatic test_reset();
    int first, nvalid;
    logic [7:0] ol, obr;
    logic ocl, ocr;
    bit early;
    rst_n = 1'b0; ena = 1'b1; lrck = 1'b0;
    voice_sample = '0; voice_vol = '0; voice_pan_l = '0; voice_pan_r = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      lrck = (i % 2 == 0);
      tests_run++;
      if ({mix_l, mix_r, mix_valid, clip_l, clip_r} !== 19'd0) begin
        tests_failed++;
        $display("FAIL reset_hold: got l=%h r=%h v=%b cl=%b cr=%b, want all zero",
                 mix_l, mix_r, mix_valid, clip_l, clip_r);
      end
    end
    // lrck already high when reset releases counts as a frame start.
    lrck = 1'b1;
    voice_sample = 32'h0000_1000; voice_vol = 16'h00F0; voice_pan_r = 4'b0010;
    tick();
    rst_n = 1'b1;
    observe(8, 1, first, nvalid, ol, obr, ocl, ocr, early);
    tests_run++;
    if (first != 5 || nvalid != 1) begin
      tests_failed++;
      $display("FAIL reset_lrck_high_timing: got first=%0d count=%0d, want first=5 count=1", first, nvalid);
    end
    tests_run++;
    if ({ol, obr, ocl, ocr} !== {8'h00, 8'h0F, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_lrck_high_value: got l=%h r=%h, want l=00 r=0f", ol, obr);
    end
    exp_l = ol; exp_r = obr; exp_cl = ocl; exp_cr = ocr;
    tick();
  endtask

  task automatic test_single_voice();
    int first, nvalid;
    logic [7:0] ol, obr;
    logic ocl, ocr;
    bit early;
    voice_sample = 32'h0000_0080; voice_vol = 16'h000F;
    voice_pan_l = 4'b0001; voice_pan_r = 4'b0000;
    lrck = 1'b1;
    observe(8, 1, first, nvalid, ol, obr, ocl, ocr, early);
    tests_run++;
    if (first != 5 || nvalid != 1 || early) begin
      tests_failed++;
      $display("FAIL single_timing: got first=%0d count=%0d early=%0d, want 5 1 0", first, nvalid, early);
    end
    tests_run++;
    if ({ol, obr, ocl, ocr} !== {8'h78, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_value: got l=%h r=%h cl=%b cr=%b, want 78 00 0 0", ol, obr, ocl, ocr);
    end
    exp_l = 8'h78; exp_r = 8'h00; exp_cl = 1'b0; exp_cr = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    int first, nvalid;
    logic [7:0] ol, obr;
    logic ocl, ocr;
    bit early;
    voice_sample = '1; voice_vol = '1; voice_pan_l = '1; voice_pan_r = '1;
    lrck = 1'b1;
    observe(8, 0, first, nvalid, ol, obr, ocl, ocr, early);
    tests_run++;
    if ({ol, obr, ocl, ocr} !== {8'hFF, 8'hFF, 1'b1, 1'b1} || first != 5) begin
      tests_failed++;
      $display("FAIL saturation: got l=%h r=%h cl=%b cr=%b first=%0d, want ff ff 1 1 5",
               ol, obr, ocl, ocr, first);
    end
    exp_l = 8'hFF; exp_r = 8'hFF; exp_cl = 1'b1; exp_cr = 1'b1;
    tick();
  endtask

  task automatic test_snapshot();
    int first, nvalid;
    logic [7:0] ol, obr;
    logic ocl, ocr;
    bit early;
    voice_sample = 32'h0000_0040; voice_vol = 16'h0008;
    voice_pan_l = 4'b0000; voice_pan_r = 4'b0001;
    lrck = 1'b1;
    observe(8, 2, first, nvalid, ol, obr, ocl, ocr, early);
    tests_run++;
    if ({ol, obr, ocl, ocr} !== {8'h00, 8'h20, 1'b0, 1'b0} || first != 5 || nvalid != 1) begin
      tests_failed++;
      $display("FAIL snapshot: got l=%h r=%h cl=%b cr=%b first=%0d, want 00 20 0 0 5",
               ol, obr, ocl, ocr, first);
    end
    exp_l = 8'h00; exp_r = 8'h20; exp_cl = 1'b0; exp_cr = 1'b0;
    voice_sample = '0; voice_vol = '0;
    tick();
  endtask

  task automatic test_restart();
    logic [VOICES*8-1:0] bs;
    logic [VOICES*4-1:0] bv;
    logic [VOICES-1:0]   bpl, bpr;
    logic [7:0] ml, mr, ol, obr;
    logic cl, cr, ocl, ocr;
    int first, nvalid;
    bit early;
    for (int off = 2; off <= 4; off++) begin
      bs = $urandom; bv = 16'($urandom); bpl = 4'($urandom); bpr = 4'($urandom);
      model(bs, bv, bpl, bpr, ml, mr, cl, cr);
      randomize_voices();
      lrck = 1'b1;
      first = -1; nvalid = 0; early = 0;
      ol = mix_l; obr = mix_r; ocl = clip_l; ocr = clip_r;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (i == 1) lrck = 1'b0;
        if (i == off) begin
          voice_sample = bs; voice_vol = bv; voice_pan_l = bpl; voice_pan_r = bpr;
          lrck = 1'b1;
        end
        if (i == off + 1) begin
          lrck = 1'b0;
          randomize_voices();
        end
        if (mix_valid === 1'b1) begin
          if (first < 0) first = i;
          nvalid++;
          ol = mix_l; obr = mix_r; ocl = clip_l; ocr = clip_r;
        end else if (first < 0 && ({mix_l, mix_r, clip_l, clip_r} !== {exp_l, exp_r, exp_cl, exp_cr})) begin
          early = 1;
        end
      end
      tests_run++;
      if (first != off + 5 || nvalid != 1 || early) begin
        tests_failed++;
        $display("FAIL restart_timing_off%0d: got first=%0d count=%0d early=%0d, want %0d 1 0",
                 off, first, nvalid, early, off + 5);
      end
      tests_run++;
      if ({ol, obr, ocl, ocr} !== {ml, mr, cl, cr}) begin
        tests_failed++;
        $display("FAIL restart_value_off%0d: got l=%h r=%h cl=%b cr=%b, want %h %h %b %b",
                 off, ol, obr, ocl, ocr, ml, mr, cl, cr);
      end
      exp_l = ml; exp_r = mr; exp_cl = cl; exp_cr = cr;
    end
  endtask

  task automatic test_ena_low();
    int nvalid;
    bit changed;
    nvalid = 0; changed = 0;
    ena = 1'b0;
    for (int i = 0; i < 48; i++) begin
      lrck = ((i % 16) < 8);
      randomize_voices();
      tick();
      if (mix_valid !== 1'b0) nvalid++;
      if ({mix_l, mix_r, clip_l, clip_r} !== {exp_l, exp_r, exp_cl, exp_cr}) changed = 1;
    end
    tests_run++;
    if (nvalid != 0 || changed) begin
      tests_failed++;
      $display("FAIL ena_low_frames: got valid_count=%0d changed=%0d, want 0 0", nvalid, changed);
    end
    lrck = 1'b0;
    tick();
    ena = 1'b1;
    tick();
    // ena dropping mid-accumulation must abort the frame silently.
    nvalid = 0; changed = 0;
    voice_sample = '1; voice_vol = '1; voice_pan_l = '1; voice_pan_r = 4'b0001;
    lrck = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) lrck = 1'b0;
      if (i == 2) ena = 1'b0;
      if (i == 3) ena = 1'b1;
      if (mix_valid !== 1'b0) nvalid++;
      if ({mix_l, mix_r, clip_l, clip_r} !== {exp_l, exp_r, exp_cl, exp_cr}) changed = 1;
    end
    tests_run++;
    if (nvalid != 0 || changed) begin
      tests_failed++;
      $display("FAIL ena_abort: got valid_count=%0d changed=%0d, want 0 0", nvalid, changed);
    end
  endtask

  task automatic test_random();
    logic [7:0] ml, mr, ol, obr;
    logic cl, cr, ocl, ocr;
    int first, nvalid;
    bit early;
    for (int f = 0; f < 40; f++) begin
      randomize_voices();
      if (f % 5 == 0) voice_vol[4*(f % VOICES) +: 4] = 4'h0;
      model(voice_sample, voice_vol, voice_pan_l, voice_pan_r, ml, mr, cl, cr);
      lrck = 1'b1;
      observe(7, 1, first, nvalid, ol, obr, ocl, ocr, early);
      tests_run++;
      if (first != 5 || nvalid != 1 || early || {ol, obr, ocl, ocr} !== {ml, mr, cl, cr}) begin
        tests_failed++;
        $display("FAIL random_frame%0d: got first=%0d count=%0d early=%0d l=%h r=%h cl=%b cr=%b, want 5 1 0 %h %h %b %b",
                 f, first, nvalid, early, ol, obr, ocl, ocr, ml, mr, cl, cr);
      end
      exp_l = ml; exp_r = mr; exp_cl = cl; exp_cr = cr;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    bit changed;
    int first;
    logic [7:0] ol, obr;
    logic ocl, ocr;
    bit early;
    voice_sample = '1; voice_vol = '1; voice_pan_l = '1; voice_pan_r = '1;
    lrck = 1'b1;
    observe(7, 0, first, nvalid, ol, obr, ocl, ocr, early);
    tests_run++;
    if ({mix_l, mix_r, clip_l, clip_r} !== {8'hFF, 8'hFF, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: got l=%h r=%h, want ff ff", mix_l, mix_r);
    end
    tick();
    lrck = 1'b1;
    tick();
    lrck = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mix_l, mix_r, mix_valid, clip_l, clip_r} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got l=%h r=%h v=%b cl=%b cr=%b, want all zero",
               mix_l, mix_r, mix_valid, clip_l, clip_r);
    end
    tick();
    rst_n = 1'b1;
    nvalid = 0; changed = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mix_valid !== 1'b0) nvalid++;
      if ({mix_l, mix_r, clip_l, clip_r} !== 18'd0) changed = 1;
    end
    tests_run++;
    if (nvalid != 0 || changed) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: got valid_count=%0d changed=%0d, want 0 0", nvalid, changed);
    end
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_saturation();
    test_snapshot();
    test_restart();
    test_ena_low();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
